// File: rtl/matmul_seq_mac.sv
// Sequential integer matrix multiplier Z = A*B (or C + A*B) using one MAC.
// Operands come from external one-cycle-latency RAMs; each Z element leaves over a stb/ack handshake.
module matmul_seq_mac #(
    parameter int M      = 4,
    parameter int K      = 4,
    parameter int N      = 4,
    parameter int DW     = 16,
    parameter int SIGNED = 1,
    parameter int ZW     = 2 * DW + $clog2(K) + 1,
    parameter int IW     = (M > 1) ? $clog2(M) : 1,
    parameter int KW     = (K > 1) ? $clog2(K) : 1,
    parameter int JW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          acc_mode,
    output logic [IW-1:0] a_row,
    output logic [KW-1:0] a_col,
    input  logic [DW-1:0] a_in,
    output logic [KW-1:0] b_row,
    output logic [JW-1:0] b_col,
    input  logic [DW-1:0] b_in,
    input  logic [ZW-1:0] c_in,
    output logic [IW-1:0] z_i,
    output logic [JW-1:0] z_j,
    output logic [ZW-1:0] z_out,
    output logic          z_stb,
    input  logic          z_ack,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [IW-1:0] I_LAST = IW'(M - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N - 1);

    state_t        state_r;
    logic [IW-1:0] i_r;
    logic [JW-1:0] j_r;
    logic [KW-1:0] k_r;
    logic [KW-1:0] mac_cnt_r;
    logic [ZW-1:0] acc_r;
    logic          acc_mode_r;

    logic [ZW-1:0] product_s;
    logic [ZW-1:0] base_s;
    logic [ZW-1:0] sum_s;
    logic [KW-1:0] k_next_s;

    function automatic logic [ZW-1:0] extend(input logic [DW-1:0] v);
        if (SIGNED != 0) begin
            extend = {{(ZW - DW){v[DW-1]}}, v};
        end else begin
            extend = {{(ZW - DW){1'b0}}, v};
        end
    endfunction

    assign a_row = i_r;
    assign z_i   = i_r;
    assign a_col = k_r;
    assign b_row = k_r;
    assign b_col = j_r;
    assign z_j   = j_r;

    assign product_s = extend(a_in) * extend(b_in);

    // Accumulator input: first dot-product term seeds from C or zero.
    always_comb begin
        base_s = acc_r;
        if (mac_cnt_r == '0) begin
            if (acc_mode_r) begin
                base_s = c_in;
            end else begin
                base_s = '0;
            end
        end else begin
            base_s = acc_r;
        end
        sum_s = base_s + product_s;
    end

    // Inner index advances one per cycle and saturates at K-1.
    always_comb begin
        if (k_r == K_LAST) begin
            k_next_s = k_r;
        end else begin
            k_next_s = k_r + KW'(1);
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            i_r        <= '0;
            j_r        <= '0;
            k_r        <= '0;
            mac_cnt_r  <= '0;
            acc_r      <= '0;
            acc_mode_r <= 1'b0;
            z_out      <= '0;
            z_stb      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        i_r        <= '0;
                        j_r        <= '0;
                        k_r        <= '0;
                        acc_mode_r <= acc_mode;
                        busy       <= 1'b1;
                        state_r    <= LOAD;
                    end
                end
                LOAD: begin
                    k_r       <= k_next_s;
                    mac_cnt_r <= '0;
                    state_r   <= MAC;
                end
                MAC: begin
                    k_r       <= k_next_s;
                    mac_cnt_r <= mac_cnt_r + KW'(1);
                    acc_r     <= sum_s;
                    if (mac_cnt_r == K_LAST) begin
                        z_out   <= sum_s;
                        z_stb   <= 1'b1;
                        state_r <= OUT;
                    end
                end
                OUT: begin
                    if (z_ack) begin
                        z_stb <= 1'b0;
                        k_r   <= '0;
                        if ((i_r == I_LAST) && (j_r == J_LAST)) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            if (j_r == J_LAST) begin
                                j_r <= '0;
                                i_r <= i_r + IW'(1);
                            end else begin
                                j_r <= j_r + JW'(1);
                            end
                            state_r <= LOAD;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/matmul_seq_mac.md
# matmul_seq_mac

Parametrised sequential integer matrix multiplier that computes Z = A·B, or Z = C + A·B in accumulate mode, for an M×K by K×N product. It succeeds the fixed-size 4×4 sequential multiplier: dimensions, data width and signedness are parameters, and it has an accumulate mode. The block reads operands from external synchronous RAMs through address ports and streams each result element out over a strobe/acknowledge handshake. It uses one pipelined MAC, so it sustains one product per cycle inside each dot product.

## Interface
- M, 4: rows of A and Z (≥1)
- K, 4: inner dimension (≥1)
- N, 4: columns of B and Z (≥1)
- DW, 16: A/B element width
- SIGNED, 1: 1 = two's-complement operands; 0 = unsigned
- ZW, 2*DW+$clog2(K)+1: result and C width (derived; do not override)
- IW/KW/JW: max(1,$clog2(M)), max(1,$clog2(K)), max(1,$clog2(N))

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- start  in  1  begin a product; sampled only in IDLE or while done=1
- acc_mode  in  1  latched at start; 1 = add C element
- a_row  out  IW  A read row (=i)
- a_col  out  KW  A read column (=k)
- a_in  in  DW  A data, valid one cycle after address
- b_row  out  KW  B read row (=k)
- b_col  out  JW  B read column (=j)
- b_in  in  DW  B data, valid one cycle after address
- c_in  in  ZW  C[z_i][z_j], valid one cycle after address
- z_i  out  IW  current result row; also C read row
- z_j  out  JW  current result column; also C read column
- z_out  out  ZW  result element
- z_stb  out  1  z_out valid
- z_ack  in  1  consumer accepts z_out
- busy  out  1  product in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, MAC, OUT.
- IDLE: if start=1, then i=j=0, latch acc_mode, busy←1, go to LOAD. A start seen while busy=1 is ignored.
- LOAD (1 cycle): present addresses for k=0 and C(i,j). Go to MAC.
- MAC (K cycles): the cycle-n product a_in·b_in is for index n−1.
  - First MAC cycle: acc ← (acc_mode_latched ? c_in : 0) + product.
  - Later MAC cycles: acc ← acc + product.
  - Addresses advance one index per cycle and hold at K−1.
  - After the K-th accumulate, z_out←acc, z_stb←1, go to OUT.
- OUT: hold z_out, z_i, z_j, z_stb stable until z_ack=1 on a clock edge. On that edge:
  - z_stb←0.
  - If (i,j)≠(M−1,N−1): step j, or wrap j to 0 and step i; go to LOAD. Order is row-major, j fastest.
  - Otherwise: done←1, busy←0, go to IDLE.
- z_ack is ignored whenever z_stb=0.
- Arithmetic:
  - Products and sums are computed at ZW bits, with operands sign-extended when SIGNED=1 and zero-extended otherwise.
  - ZW bits hold any K-term sum plus C without overflow when C fits in 2·DW+clog2(K) bits. Wider C wraps modulo 2^ZW.
- done is high for exactly one cycle. start in that same cycle is accepted, giving back-to-back runs.
- K=1 is legal: MAC lasts one cycle.
- M=1 or N=1 is legal: the index stays 0.
- Reset values: z_out=0, z_stb=0, done=0, busy=0, all address outputs=0, state IDLE, acc=0.
- Reset mid-operation aborts at once with no partial output. Counters clear. The next start begins from element (0,0).

## Timing
- Call the edge that samples start edge 0.
- LOAD occupies cycle 0→1. Then the MAC cycles run.
- z_stb rises at edge K+1.
- Element period with z_ack held high: K+2 cycles.
- Full run with z_ack held high: done rises at edge M·N·(K+2).
- Backpressure: each cycle z_ack stays low after z_stb rises adds one cycle. Addresses and z_out stay frozen meanwhile.
- Memory contract: registered read, one-cycle latency, no stall. a_in, b_in and c_in must reflect the previous cycle's addresses.

## Test plan
- 2×2×2, SIGNED=1, A=[[1,2],[3,4]], B=identity, z_ack=1 → Z=1,2,3,4 in order (0,0),(0,1),(1,0),(1,1). Strobes at edges 3,7,11,15; done at edge 16 only.
- Same A and B, acc_mode=1, C=[[10,10],[10,10]] → 11,12,13,14. A run with acc_mode=0 ignores C.
- SIGNED=1, DW=8, K=4, all A=B=−128 → every z_out = 65536. SIGNED=0 with all 0xFF → 4·65025 = 260100.
- M=2, K=3, N=4, random data, z_ack low for 3 cycles on every element → 8 results match the model. z_out is stable while stalled, and each element transfers exactly once.
- K=1, M=N=3, z_ack tied high → 9 results, one per 3 cycles. start asserted with done → second run starts with no gap.
- rst asserted mid-MAC of element (1,0) → next edge all outputs at reset values. A fresh start reproduces the full correct Z from (0,0).
